// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : RV64I decode with write-back bypass, load-use detection and ID/EX register
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall_if,
    output logic            ex_valid,
    output logic [6:0]      ex_opcode,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_alusrc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_vala,
    output logic [XLEN-1:0] ex_valb,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_regwrite,
    output logic            ex_branch,
    output logic            ex_illegal
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b;
    logic [XLEN-1:0] w_imm, w_vala, w_valb;
    logic            w_alusrc, w_memread, w_memwrite, w_regwrite, w_branch;
    logic            w_uses_rs2, w_illegal, w_hazard;

    assign w_opcode  = if_instr[6:0];
    assign w_rd      = if_instr[11:7];
    assign rf_raddr1 = if_instr[19:15];
    assign rf_raddr2 = if_instr[24:20];

    assign w_imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};

    always_comb begin
        w_alusrc   = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_branch   = 1'b0;
        w_uses_rs2 = 1'b0;
        w_illegal  = 1'b0;
        w_imm      = '0;
        case (w_opcode)
            c_op_r: begin
                w_regwrite = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            c_op_imm: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
                w_imm      = w_imm_i;
            end
            c_op_load: begin
                w_alusrc   = 1'b1;
                w_memread  = 1'b1;
                w_regwrite = 1'b1;
                w_imm      = w_imm_i;
            end
            c_op_store: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm      = w_imm_s;
            end
            c_op_branch: begin
                w_branch   = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm      = w_imm_b;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // x0 is hardwired; a same-cycle write-back overrides the stale register-file read.
    assign w_vala = (rf_raddr1 == 5'd0) ? '0 :
                    (wb_we && wb_rd != 5'd0 && wb_rd == rf_raddr1) ? wb_data : rf_rdata1;
    assign w_valb = (rf_raddr2 == 5'd0) ? '0 :
                    (wb_we && wb_rd != 5'd0 && wb_rd == rf_raddr2) ? wb_data : rf_rdata2;

    assign w_hazard = if_valid && ex_valid && ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == rf_raddr1) || (w_uses_rs2 && ex_rd == rf_raddr2));
    assign stall_if = w_hazard && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_alusrc   <= 1'b0;
            ex_imm      <= '0;
            ex_vala     <= '0;
            ex_valb     <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
        end else begin
            // Bubble by default; only a legal, unblocked instruction overwrites it.
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_alusrc   <= 1'b0;
            ex_imm      <= '0;
            ex_vala     <= '0;
            ex_valb     <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_illegal  <= 1'b0;
            if (!flush && !w_hazard && if_valid) begin
                if (w_illegal) begin
                    ex_illegal <= 1'b1;
                end else begin
                    ex_valid    <= 1'b1;
                    ex_opcode   <= w_opcode;
                    ex_rs1      <= rf_raddr1;
                    ex_rs2      <= rf_raddr2;
                    ex_rd       <= w_rd;
                    ex_funct3   <= if_instr[14:12];
                    ex_funct7   <= if_instr[31:25];
                    ex_alusrc   <= w_alusrc;
                    ex_imm      <= w_imm;
                    ex_vala     <= w_vala;
                    ex_valb     <= w_valb;
                    ex_memread  <= w_memread;
                    ex_memwrite <= w_memwrite;
                    ex_regwrite <= w_regwrite;
                    ex_branch   <= w_branch;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed self-checking bench for id_ex_stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [4:0]      rf_raddr1, rf_raddr2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            stall_if;
    logic            ex_valid;
    logic [6:0]      ex_opcode;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic            ex_alusrc;
    logic [XLEN-1:0] ex_imm, ex_vala, ex_valb;
    logic            ex_memread, ex_memwrite, ex_regwrite, ex_branch, ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .stall_if(stall_if), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_alusrc(ex_alusrc),
        .ex_imm(ex_imm), .ex_vala(ex_vala), .ex_valb(ex_valb),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        if_valid  = 1'b1;
        if_instr  = 32'hFFF00293;       // addi x5, x0, -1
        rf_rdata1 = 64'hDEAD;
        rf_rdata2 = 64'h200;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = '0;
        flush     = 1'b0;

        // Reset holds the register cleared even with a valid instruction presented
        tick();
        tick();
        chk("rst_valid",   ex_valid, 0);
        chk("rst_opcode",  ex_opcode, 0);
        chk("rst_rd",      ex_rd, 0);
        chk("rst_imm",     ex_imm, 0);
        chk("rst_alusrc",  ex_alusrc, 0);
        chk("rst_regwr",   ex_regwrite, 0);
        chk("rst_illegal", ex_illegal, 0);
        chk("raddr1",      rf_raddr1, 0);
        chk("raddr2",      rf_raddr2, 31);

        rst_n = 1'b1;
        tick();
        chk("addi_valid",  ex_valid, 1);
        chk("addi_opcode", ex_opcode, 7'h13);
        chk("addi_rd",     ex_rd, 5);
        chk("addi_alusrc", ex_alusrc, 1);
        chk("addi_imm",    ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_vala",   ex_vala, 0);
        chk("addi_regwr",  ex_regwrite, 1);

        // Store: sd x2, 8(x1)
        if_instr  = 32'h0020B423;
        rf_rdata1 = 64'h100;
        rf_rdata2 = 64'h200;
        tick();
        chk("st_imm",    ex_imm, 8);
        chk("st_alusrc", ex_alusrc, 1);
        chk("st_memwr",  ex_memwrite, 1);
        chk("st_regwr",  ex_regwrite, 0);
        chk("st_rs1",    ex_rs1, 1);
        chk("st_rs2",    ex_rs2, 2);
        chk("st_funct3", ex_funct3, 3);
        chk("st_vala",   ex_vala, 64'h100);
        chk("st_valb",   ex_valb, 64'h200);

        // Branch with negative offset -4
        if_instr = 32'hFE208EE3;
        tick();
        chk("br_imm",    ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("br_alusrc", ex_alusrc, 0);
        chk("br_branch", ex_branch, 1);
        chk("br_funct7", ex_funct7, 7'h7F);

        // Load-use: ld x6, 0(x1) then add x7, x6, x2
        if_instr = 32'h0000B303;
        tick();
        chk("ld_memread", ex_memread, 1);
        chk("ld_rd",      ex_rd, 6);
        if_instr = 32'h002303B3;
        #1;
        chk("lu_stall",   stall_if, 1);
        tick();
        chk("lu_bubble",  ex_valid, 0);
        chk("lu_bub_mr",  ex_memread, 0);
        chk("lu_stall_clear", stall_if, 0);
        wb_we   = 1'b1;
        wb_rd   = 5'd6;
        wb_data = 64'h55;
        #1;
        chk("lu_stall_off", stall_if, 0);
        tick();
        chk("add_valid",  ex_valid, 1);
        chk("add_rs1",    ex_rs1, 6);
        chk("add_rd",     ex_rd, 7);
        chk("add_opcode", ex_opcode, 7'h33);
        chk("add_imm",    ex_imm, 0);
        chk("add_vala_byp", ex_vala, 64'h55);
        chk("add_valb",   ex_valb, 64'h200);

        // rs2 bypass on the same add
        wb_rd   = 5'd2;
        wb_data = 64'h77;
        tick();
        chk("add_valb_byp", ex_valb, 64'h77);
        chk("add_vala_rf",  ex_vala, 64'h100);

        // Bypass on rs1=1: addi x3, x1, 5
        if_instr  = 32'h00508193;
        rf_rdata1 = 64'h11;
        wb_we     = 1'b1;
        wb_rd     = 5'd1;
        wb_data   = 64'h22;
        tick();
        chk("byp_vala", ex_vala, 64'h22);
        chk("byp_imm",  ex_imm, 5);
        wb_we = 1'b0;
        tick();
        chk("nobyp_vala", ex_vala, 64'h11);
        // x0 source with wb_rd=0 stays zero: addi x3, x0, 5
        if_instr = 32'h00500193;
        wb_we    = 1'b1;
        wb_rd    = 5'd0;
        tick();
        chk("x0_vala", ex_vala, 0);
        wb_we = 1'b0;

        // Invalid fetch slot gives a bubble
        if_valid = 1'b0;
        tick();
        chk("inval_valid", ex_valid, 0);
        chk("inval_rd",    ex_rd, 0);
        if_valid = 1'b1;

        // Flush over hazard
        if_instr = 32'h0000B303;
        tick();
        chk("fl_ld_valid", ex_valid, 1);
        if_instr = 32'h002303B3;
        flush    = 1'b1;
        #1;
        chk("fl_stall", stall_if, 0);
        tick();
        chk("fl_valid", ex_valid, 0);
        chk("fl_rd",    ex_rd, 0);
        flush    = 1'b0;
        if_valid = 1'b0;
        tick();
        chk("fl_after_valid", ex_valid, 0);
        if_valid = 1'b1;

        // Illegal opcode pulses ex_illegal once
        if_instr = 32'h0000007F;
        tick();
        chk("ill_valid", ex_valid, 0);
        chk("ill_flag",  ex_illegal, 1);
        chk("ill_opc",   ex_opcode, 0);
        if_instr = 32'h00500193;
        tick();
        chk("ill_clear", ex_illegal, 0);
        chk("ill_next_valid", ex_valid, 1);

        // Asynchronous reset clears without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", ex_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register of the pipelined RV64I core. It is the producer side of the execute-stage input interface. It takes a fetched 32-bit instruction and reads the register file. It generates the immediate and `alusrc`, applies write-back bypass, detects load-use hazards and registers everything into ID/EX, which drives the execute stage's opcode/rs1/rs2/rd/funct3/funct7/alusrc/imm/ValA/ValB inputs.

## Interface
Parameters:
- `XLEN`, default 64: datapath width. The immediate and operands are sign-extended to this width.

Ports:
- `clk`: input, 1. Rising-edge clock.
- `rst_n`: input, 1. Asynchronous, active-low reset.
- `if_valid`: input, 1. `if_instr` holds a valid instruction.
- `if_instr`: input, 32. Instruction in ID.
- `rf_raddr1`, `rf_raddr2`: output, 5 each. Combinational. Equal to `if_instr[19:15]` and `if_instr[24:20]`.
- `rf_rdata1`, `rf_rdata2`: input, XLEN each. Register-file read data for those addresses.
- `wb_we`: input, 1. Write-back write enable.
- `wb_rd`: input, 5. Write-back destination register.
- `wb_data`: input, XLEN. Write-back data.
- `flush`: input, 1. Taken branch resolved in EX. Kills the instruction in ID.
- `stall_if`: output, 1. Combinational. Load-use stall. Fetch must hold PC and `if_instr`.
- `ex_valid`: output, 1. Registered. ID/EX holds a real instruction.
- `ex_opcode`: output, 7. Registered.
- `ex_rs1`, `ex_rs2`, `ex_rd`: output, 5 each. Registered.
- `ex_funct3`: output, 3. Registered.
- `ex_funct7`: output, 7. Registered.
- `ex_alusrc`: output, 1. Registered. 1 selects `ex_imm` as ALU operand B.
- `ex_imm`: output, XLEN. Registered.
- `ex_vala`, `ex_valb`: output, XLEN each. Registered. Operand values.
- `ex_memread`, `ex_memwrite`, `ex_regwrite`, `ex_branch`: output, 1 each. Registered control bits.
- `ex_illegal`: output, 1. Registered. One-cycle pulse for an unsupported opcode.

## Operation
Decode (combinational, from `if_instr`):
- Opcode `0110011` (R): `alusrc`=0, `regwrite`=1, `imm`=0. Uses rs1 and rs2.
- Opcode `0010011` (I-ALU): `alusrc`=1, `regwrite`=1. Uses rs1.
- Opcode `0000011` (load): `alusrc`=1, `memread`=1, `regwrite`=1. Uses rs1.
- Opcode `0100011` (store): `alusrc`=1, `memwrite`=1. Uses rs1 and rs2.
- Opcode `1100011` (branch): `alusrc`=0, `branch`=1. Uses rs1 and rs2.
- Any other opcode is illegal.

Immediate generation, sign-extended from bit 31 to XLEN:
- I-type: `instr[31:20]`.
- S-type: `{instr[31:25], instr[11:7]}`.
- B-type: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.

Operand values:
- Source register x0 reads as 0 regardless of `rf_rdata*`.
- Write-back bypass: if `wb_we` is 1, `wb_rd`!=0 and `wb_rd` equals the source register, the operand is `wb_data`. Otherwise it is `rf_rdata*`.

Load-use hazard:
- `hazard` = `if_valid` & `ex_valid` & `ex_memread` & `ex_rd`!=0 & (`ex_rd`==rs1 | (uses_rs2 & `ex_rd`==rs2)).
- `stall_if` = `hazard` & !`flush`.

ID/EX update at each rising edge, in priority order:
1. `flush`: load a bubble.
2. `hazard`: load a bubble.
3. `!if_valid`: load a bubble.
4. Illegal opcode: load a bubble with `ex_illegal`=1.
5. Otherwise: load the decoded fields, operands and controls, with `ex_valid`=1.

Bubble definition:
- All registered outputs are 0, including data fields.
- `ex_illegal` is set only as stated in step 4.

Reset:
- While `rst_n`=0, all registered outputs are 0.
- Deassertion takes effect at the next rising edge.

## Timing
- Latency is 1 cycle. An instruction presented in cycle n appears on the `ex_*` outputs after the rising edge that ends cycle n.
- `stall_if`, `rf_raddr1` and `rf_raddr2` are combinational in the same cycle.
- A load-use pair costs exactly one bubble:
  - Cycle n: `stall_if`=1 and the bubble enters ID/EX.
  - Cycle n+1: the load has left EX, `stall_if`=0 and the dependent instruction issues.
- `flush` together with `hazard`: `stall_if`=0, a bubble enters ID/EX and the ID instruction is discarded.
- Back-to-back non-dependent instructions issue one per cycle with no bubbles.
- Write-back to the register being read in the same cycle returns `wb_data`, never stale data.

## Test plan
- Reset: hold `rst_n`=0 with `if_instr`=0xFFF00293 and `if_valid`=1. All `ex_*` outputs must read 0. Release reset. After the next rising edge: `ex_valid`=1, `ex_opcode`=0x13, `ex_rd`=5, `ex_alusrc`=1, `ex_imm`=0xFFFF_FFFF_FFFF_FFFF, `ex_vala`=0.
- Immediate formats:
  - Store 0x0020B423: `ex_imm`=8, `ex_alusrc`=1, `ex_memwrite`=1, `ex_rs1`=1, `ex_rs2`=2.
  - Branch 0xFE208EE3: `ex_imm`=0xFFFF_FFFF_FFFF_FFFC, `ex_alusrc`=0, `ex_branch`=1.
- Load-use stall: issue 0x0000B303 (ld x6), then present 0x002303B3 (add x7,x6,x2).
  - `stall_if`=1 for exactly one cycle, with the fetch holding the add.
  - One bubble cycle with `ex_valid`=0.
  - Then the add issues with `ex_rs1`=6 and `ex_valid`=1.
- Bypass: present `rf_rdata1`=0x11 for rs1=1 with `wb_we`=1, `wb_rd`=1, `wb_data`=0x22. Result: `ex_vala`=0x22. Repeat with `wb_rd`=0 targeting rs1=0: `ex_vala`=0.
- Flush over hazard: reproduce the load-use case with `flush`=1 in the stall cycle. Result: `stall_if`=0, the next `ex_valid`=0, and the add is not issued from that cycle.
- Illegal opcode: present `if_instr`=0x0000007F. Result: `ex_valid`=0 and `ex_illegal`=1 for one cycle, then 0 when followed by a legal instruction.
